// File: rtl/nyq_cfg_ctrl_pkg.sv
// nyq_cfg_pkg: shared state encoding and NYQ address map for the config sequencer
package nyq_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_LOAD = 3'd2,
        ST_ARM  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam int NYQ_DONE_ADDR = 32;
    localparam int NYQ_NUM_COEF  = 32;
    localparam int LOAD_DONE_BIT = 0;

endpackage

// File: rtl/nyq_cfg_ctrl_if.sv
// nyq_cfg_ctrl_if: coefficient stream, NYQ parameter-write bus and status of the config sequencer
interface nyq_cfg_ctrl_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int MEM_WIDTH  = 24
);
    logic                  Start_SI;
    logic [MEM_WIDTH-1:0]  Coef_DI;
    logic                  CoefValid_SI;
    logic                  CoefReady_SO;
    logic                  WrEn_SO;
    logic [ADDR_WIDTH-1:0] Addr_DO;
    logic [MEM_WIDTH-1:0]  PAR_Out_DO;
    logic                  Busy_SO;
    logic                  Done_SO;
    logic                  Err_SO;

    modport master (
        output Start_SI, Coef_DI, CoefValid_SI,
        input  CoefReady_SO, WrEn_SO, Addr_DO, PAR_Out_DO, Busy_SO, Done_SO, Err_SO
    );

    modport slave (
        input  Start_SI, Coef_DI, CoefValid_SI,
        output CoefReady_SO, WrEn_SO, Addr_DO, PAR_Out_DO, Busy_SO, Done_SO, Err_SO
    );

endinterface

// File: rtl/nyq_cfg_ctrl_stall_timer.sv
// cfg_stall_timer: saturating stall counter with clear/enable and terminal-count flag
module cfg_stall_timer #(
    parameter int TERMINAL = 255
) (
    input  logic Clk_CI,
    input  logic Rst_RBI,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam int W = (TERMINAL > 1) ? $clog2(TERMINAL + 1) : 1;

    logic [W-1:0] cnt_q;

    assign tc = (cnt_q == W'(TERMINAL));

    // count enabled cycles, hold at the terminal value, clear has priority
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !tc) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/nyq_cfg_ctrl.sv
// nyq_cfg_ctrl: clears load-done, streams NUM_COEF coefficients into NYQ, then arms it
module nyq_cfg_ctrl
    import nyq_cfg_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int MEM_WIDTH  = 24,
    parameter int NUM_COEF   = NYQ_NUM_COEF,
    parameter int DONE_ADDR  = NYQ_DONE_ADDR,
    parameter int TIMEOUT    = 255
) (
    input logic           Clk_CI,
    input logic           Rst_RBI,
    nyq_cfg_ctrl_if.slave cfg
);
    localparam int IDX_W = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;
    localparam logic [ADDR_WIDTH-1:0] DONE_A    = ADDR_WIDTH'(DONE_ADDR);
    localparam logic [MEM_WIDTH-1:0]  DONE_WORD = MEM_WIDTH'(1) << LOAD_DONE_BIT;
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_COEF - 1);

    state_e                state_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [MEM_WIDTH-1:0]  par_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic                  stall_tc;
    logic                  ready;
    logic                  accept;
    logic                  start_ok;

    // ready drops in the abort cycle so no beat is taken and then discarded
    assign ready    = (state_q == ST_LOAD) && !stall_tc;
    assign accept   = ready && cfg.CoefValid_SI;
    assign start_ok = cfg.Start_SI && (state_q == ST_IDLE || state_q == ST_DONE);

    cfg_stall_timer #(
        .TERMINAL(TIMEOUT)
    ) u_stall (
        .Clk_CI (Clk_CI),
        .Rst_RBI(Rst_RBI),
        .clr    (state_q != ST_LOAD || accept),
        .en     (state_q == ST_LOAD),
        .tc     (stall_tc)
    );

    // sequencer: every bus write is registered so it appears in the cycle after its cause
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            par_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (start_ok) begin
                state_q <= ST_CLR;
                wr_en_q <= 1'b1;
                addr_q  <= DONE_A;
                par_q   <= '0;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
                err_q   <= 1'b0;
                idx_q   <= '0;
            end else begin
                case (state_q)
                    ST_CLR: state_q <= ST_LOAD;
                    ST_LOAD: begin
                        if (stall_tc) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                            idx_q   <= '0;
                        end else if (accept) begin
                            wr_en_q <= 1'b1;
                            addr_q  <= ADDR_WIDTH'(idx_q);
                            par_q   <= cfg.Coef_DI;
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= (idx_q == LAST_IDX) ? ST_ARM : ST_LOAD;
                        end
                    end
                    ST_ARM: begin
                        state_q <= ST_DONE;
                        wr_en_q <= 1'b1;
                        addr_q  <= DONE_A;
                        par_q   <= DONE_WORD;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        idx_q   <= '0;
                    end
                    default: state_q <= state_q;
                endcase
            end
        end
    end

    assign cfg.CoefReady_SO = ready;
    assign cfg.WrEn_SO      = wr_en_q;
    assign cfg.Addr_DO      = addr_q;
    assign cfg.PAR_Out_DO   = par_q;
    assign cfg.Busy_SO      = busy_q;
    assign cfg.Done_SO      = done_q;
    assign cfg.Err_SO       = err_q;

endmodule

// File: tb/tb_nyq_cfg_ctrl.sv
// tb_nyq_cfg_ctrl: directed scenarios for the NYQ configuration sequencer
module tb_nyq_cfg_ctrl;
    localparam int AW = 6;
    localparam int MW = 24;
    localparam int NC = 32;
    localparam int DA = 32;
    localparam int TO = 255;

    logic Clk_CI  = 1'b0;
    logic Rst_RBI = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   base = 0;
    int   done_cyc = -1;
    logic done_prev = 1'b0;
    int   log_cyc[$];
    int   log_addr[$];
    logic [MW-1:0] log_data[$];

    nyq_cfg_ctrl_if #(.ADDR_WIDTH(AW), .MEM_WIDTH(MW)) cfg ();

    nyq_cfg_ctrl #(
        .ADDR_WIDTH(AW), .MEM_WIDTH(MW), .NUM_COEF(NC), .DONE_ADDR(DA), .TIMEOUT(TO)
    ) dut (
        .Clk_CI (Clk_CI),
        .Rst_RBI(Rst_RBI),
        .cfg    (cfg)
    );

    always #5 Clk_CI = ~Clk_CI;

    always @(posedge Clk_CI) cyc <= cyc + 1;

    // bus monitor: logs every write and the first cycle of each Done_SO rise
    always @(negedge Clk_CI) begin
        if (cfg.WrEn_SO === 1'b1) begin
            log_cyc.push_back(cyc);
            log_addr.push_back(int'(cfg.Addr_DO));
            log_data.push_back(cfg.PAR_Out_DO);
        end
        if (cfg.Done_SO === 1'b1 && !done_prev) done_cyc = cyc;
        done_prev = (cfg.Done_SO === 1'b1);
    end

    function automatic int exp_cyc(input int i, input int ga, input int gl);
        if (i == 0) return 1;
        if (i == NC + 1) return NC + 3 + gl;
        return i + 2 + ((ga >= 0 && i - 1 > ga) ? gl : 0);
    endfunction

    function automatic int exp_addr(input int i);
        return (i == 0 || i == NC + 1) ? DA : i - 1;
    endfunction

    function automatic logic [MW-1:0] exp_data(input int i, input logic [MW-1:0] first);
        if (i == 0) return '0;
        if (i == NC + 1) return MW'(1);
        return MW'(first + MW'(i - 1));
    endfunction

    task automatic clear_log();
        log_cyc.delete();
        log_addr.delete();
        log_data.delete();
        done_cyc = -1;
    endtask

    task automatic start_seq();
        @(posedge Clk_CI); #1;
        clear_log();
        base = cyc;
        cfg.Start_SI = 1'b1;
        @(posedge Clk_CI); #1;
        cfg.Start_SI = 1'b0;
    endtask

    task automatic send_coefs(input int n, input logic [MW-1:0] first, input int gap_after, input int gap_len);
        int k = 0;
        int gap = 0;
        int guard = 0;
        cfg.Coef_DI = first;
        cfg.CoefValid_SI = (n > 0);
        while (k < n && guard < 2000) begin
            @(negedge Clk_CI);
            if (cfg.CoefValid_SI && cfg.CoefReady_SO) begin
                if (k == gap_after) gap = gap_len;
                k++;
            end else if (!cfg.CoefValid_SI && gap > 0) gap--;
            @(posedge Clk_CI); #1;
            cfg.CoefValid_SI = (k < n) && (gap == 0);
            cfg.Coef_DI = MW'(first + MW'(k));
            guard++;
        end
        cfg.CoefValid_SI = 1'b0;
        if (k < n) begin
            vectors++;
            miscompares++;
            $display("FAIL send_coefs: accepted %0d beats, required %0d", k, n);
        end
    endtask

    task automatic test_reset();
        logic [AW+MW+5:0] obs;
        #3 Rst_RBI = 1'b0;
        #2;
        obs = {cfg.WrEn_SO, cfg.Addr_DO, cfg.PAR_Out_DO, cfg.CoefReady_SO, cfg.Busy_SO, cfg.Done_SO, cfg.Err_SO};
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %0h, required 0", obs);
        end
        repeat (2) @(posedge Clk_CI);
        #1 Rst_RBI = 1'b1;
        repeat (3) @(posedge Clk_CI);
        #1;
        obs = {cfg.WrEn_SO, cfg.Addr_DO, cfg.PAR_Out_DO, cfg.CoefReady_SO, cfg.Busy_SO, cfg.Done_SO, cfg.Err_SO};
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %0h, required 0", obs);
        end
    endtask

    task automatic test_full_load();
        start_seq();
        send_coefs(NC, MW'(1), -1, 0);
        repeat (4) @(posedge Clk_CI);
        #1;
        vectors++;
        if (log_cyc.size() != NC + 2) begin
            miscompares++;
            $display("FAIL full_wr_count: got %0d writes, required %0d", log_cyc.size(), NC + 2);
        end
        for (int i = 0; i < NC + 2; i++) begin
            vectors++;
            if (i >= log_cyc.size()) begin
                miscompares++;
                $display("FAIL full_wr%0d: missing, required cyc %0d addr %0d", i, exp_cyc(i, -1, 0), exp_addr(i));
            end else if (log_cyc[i] - base != exp_cyc(i, -1, 0) || log_addr[i] != exp_addr(i) || log_data[i] !== exp_data(i, MW'(1))) begin
                miscompares++;
                $display("FAIL full_wr%0d: got cyc %0d addr %0d data %0h, required cyc %0d addr %0d data %0h",
                         i, log_cyc[i] - base, log_addr[i], log_data[i], exp_cyc(i, -1, 0), exp_addr(i), exp_data(i, MW'(1)));
            end
        end
        vectors++;
        if (done_cyc - base != NC + 3 || cfg.Done_SO !== 1'b1 || cfg.Busy_SO !== 1'b0) begin
            miscompares++;
            $display("FAIL full_done: got rise cyc %0d done %b busy %b, required cyc %0d done 1 busy 0",
                     done_cyc - base, cfg.Done_SO, cfg.Busy_SO, NC + 3);
        end
    endtask

    task automatic test_gap();
        start_seq();
        send_coefs(NC, MW'(1), 14, 10);
        repeat (4) @(posedge Clk_CI);
        #1;
        vectors++;
        if (log_cyc.size() != NC + 2) begin
            miscompares++;
            $display("FAIL gap_wr_count: got %0d writes, required %0d", log_cyc.size(), NC + 2);
        end
        for (int i = 0; i < NC + 2; i++) begin
            vectors++;
            if (i >= log_cyc.size()) begin
                miscompares++;
                $display("FAIL gap_wr%0d: missing, required cyc %0d addr %0d", i, exp_cyc(i, 14, 10), exp_addr(i));
            end else if (log_cyc[i] - base != exp_cyc(i, 14, 10) || log_addr[i] != exp_addr(i) || log_data[i] !== exp_data(i, MW'(1))) begin
                miscompares++;
                $display("FAIL gap_wr%0d: got cyc %0d addr %0d data %0h, required cyc %0d addr %0d data %0h",
                         i, log_cyc[i] - base, log_addr[i], log_data[i], exp_cyc(i, 14, 10), exp_addr(i), exp_data(i, MW'(1)));
            end
        end
        vectors++;
        if (done_cyc - base != NC + 13) begin
            miscompares++;
            $display("FAIL gap_done: got rise cyc %0d, required %0d", done_cyc - base, NC + 13);
        end
    endtask

    task automatic test_timeout();
        int err_cyc = -1;
        int n_done_wr = 0;
        start_seq();
        send_coefs(5, MW'(100), -1, 0);
        repeat (240) @(posedge Clk_CI);
        #1;
        vectors++;
        if (cfg.Err_SO !== 1'b0 || cfg.Busy_SO !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_early: got err %b busy %b at cyc %0d, required err 0 busy 1", cfg.Err_SO, cfg.Busy_SO, cyc - base);
        end
        for (int i = 0; i < 100 && err_cyc < 0; i++) begin
            @(negedge Clk_CI);
            if (cfg.Err_SO === 1'b1) err_cyc = cyc - base;
        end
        vectors++;
        if (err_cyc < 258 || err_cyc > 266) begin
            miscompares++;
            $display("FAIL timeout_cycle: got err rise cyc %0d, required 258..266", err_cyc);
        end
        vectors++;
        if (cfg.Busy_SO !== 1'b0 || cfg.Done_SO !== 1'b0 || cfg.CoefReady_SO !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_status: got busy %b done %b ready %b, required 0 0 0", cfg.Busy_SO, cfg.Done_SO, cfg.CoefReady_SO);
        end
        foreach (log_addr[i]) if (log_addr[i] == DA) n_done_wr++;
        vectors++;
        if (log_cyc.size() != 6 || n_done_wr != 1 || log_data[0] !== '0) begin
            miscompares++;
            $display("FAIL timeout_writes: got %0d writes, %0d to done addr, required 6 and 1 (clear only)", log_cyc.size(), n_done_wr);
        end
    endtask

    task automatic test_start_ignored();
        int n_done_wr = 0;
        start_seq();
        vectors++;
        if (cfg.Err_SO !== 1'b0 || cfg.Busy_SO !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_after_err: got err %b busy %b, required err 0 busy 1", cfg.Err_SO, cfg.Busy_SO);
        end
        send_coefs(10, MW'(200), -1, 0);
        cfg.Start_SI = 1'b1;
        @(posedge Clk_CI); #1;
        cfg.Start_SI = 1'b0;
        vectors++;
        if (cfg.Busy_SO !== 1'b1 || cfg.CoefReady_SO !== 1'b1) begin
            miscompares++;
            $display("FAIL start_in_load: got busy %b ready %b, required 1 1", cfg.Busy_SO, cfg.CoefReady_SO);
        end
        send_coefs(NC - 10, MW'(210), -1, 0);
        repeat (4) @(posedge Clk_CI);
        #1;
        foreach (log_addr[i]) if (log_addr[i] == DA) n_done_wr++;
        vectors++;
        if (log_cyc.size() != NC + 2 || n_done_wr != 2 || cfg.Done_SO !== 1'b1) begin
            miscompares++;
            $display("FAIL ignored_summary: got %0d writes, %0d done-addr writes, done %b, required %0d 2 1",
                     log_cyc.size(), n_done_wr, cfg.Done_SO, NC + 2);
        end
        for (int i = 1; i <= NC && i < log_cyc.size(); i++) begin
            vectors++;
            if (log_addr[i] != i - 1 || log_data[i] !== MW'(199 + i)) begin
                miscompares++;
                $display("FAIL ignored_wr%0d: got addr %0d data %0h, required addr %0d data %0h",
                         i, log_addr[i], log_data[i], i - 1, MW'(199 + i));
            end
        end
    endtask

    task automatic test_reload();
        logic [MW-1:0] first = 24'hFFFFF0;
        start_seq();
        vectors++;
        if (cfg.Done_SO !== 1'b0 || cfg.Busy_SO !== 1'b1 || cfg.WrEn_SO !== 1'b1 ||
            cfg.Addr_DO !== AW'(DA) || cfg.PAR_Out_DO !== '0) begin
            miscompares++;
            $display("FAIL reload_clr: got done %b busy %b wr %b addr %0d par %0h, required 0 1 1 %0d 0",
                     cfg.Done_SO, cfg.Busy_SO, cfg.WrEn_SO, cfg.Addr_DO, cfg.PAR_Out_DO, DA);
        end
        send_coefs(NC, first, -1, 0);
        repeat (4) @(posedge Clk_CI);
        #1;
        vectors++;
        if (log_cyc.size() != NC + 2 || done_cyc - base != NC + 3) begin
            miscompares++;
            $display("FAIL reload_summary: got %0d writes, done cyc %0d, required %0d and %0d",
                     log_cyc.size(), done_cyc - base, NC + 2, NC + 3);
        end
        for (int i = 0; i < NC + 2 && i < log_cyc.size(); i++) begin
            vectors++;
            if (log_cyc[i] - base != exp_cyc(i, -1, 0) || log_addr[i] != exp_addr(i) || log_data[i] !== exp_data(i, first)) begin
                miscompares++;
                $display("FAIL reload_wr%0d: got cyc %0d addr %0d data %0h, required cyc %0d addr %0d data %0h",
                         i, log_cyc[i] - base, log_addr[i], log_data[i], exp_cyc(i, -1, 0), exp_addr(i), exp_data(i, first));
            end
        end
    endtask

    task automatic test_reset_mid_load();
        int n0;
        logic [AW+MW+5:0] obs;
        start_seq();
        send_coefs(20, MW'(300), -1, 0);
        Rst_RBI = 1'b0;
        #1;
        obs = {cfg.WrEn_SO, cfg.Addr_DO, cfg.PAR_Out_DO, cfg.CoefReady_SO, cfg.Busy_SO, cfg.Done_SO, cfg.Err_SO};
        n0 = log_cyc.size();
        vectors++;
        if (obs !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs: got %0h, required 0", obs);
        end
        repeat (2) @(posedge Clk_CI);
        #1 Rst_RBI = 1'b1;
        repeat (4) @(posedge Clk_CI);
        #1;
        obs = {cfg.WrEn_SO, cfg.Addr_DO, cfg.PAR_Out_DO, cfg.CoefReady_SO, cfg.Busy_SO, cfg.Done_SO, cfg.Err_SO};
        vectors++;
        if (obs !== '0 || log_cyc.size() != n0) begin
            miscompares++;
            $display("FAIL mid_reset_idle: got outputs %0h and %0d writes, required 0 and %0d", obs, log_cyc.size(), n0);
        end
        start_seq();
        send_coefs(NC, MW'(400), -1, 0);
        repeat (4) @(posedge Clk_CI);
        #1;
        vectors++;
        if (log_cyc.size() != NC + 2 || done_cyc - base != NC + 3) begin
            miscompares++;
            $display("FAIL restart_summary: got %0d writes, done cyc %0d, required %0d and %0d",
                     log_cyc.size(), done_cyc - base, NC + 2, NC + 3);
        end
        for (int i = 0; i < NC + 2 && i < log_cyc.size(); i++) begin
            vectors++;
            if (log_cyc[i] - base != exp_cyc(i, -1, 0) || log_addr[i] != exp_addr(i) || log_data[i] !== exp_data(i, MW'(400))) begin
                miscompares++;
                $display("FAIL restart_wr%0d: got cyc %0d addr %0d data %0h, required cyc %0d addr %0d data %0h",
                         i, log_cyc[i] - base, log_addr[i], log_data[i], exp_cyc(i, -1, 0), exp_addr(i), exp_data(i, MW'(400)));
            end
        end
    endtask

    initial begin
        cfg.Start_SI = 1'b0;
        cfg.Coef_DI = '0;
        cfg.CoefValid_SI = 1'b0;
        test_reset();
        test_full_load();
        test_gap();
        test_timeout();
        test_start_ignored();
        test_reload();
        test_reset_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
